seg_disp_arbiter: RTL

//  Shares the 6-digit seven-segment display between NUM_SRC value producers (frequency, amplitude,

---
 rtl/seg_disp_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/seg_disp_arbiter.sv
// rtl/seg_disp_arbiter.sv - seven-segment display source arbiter with switch blanking and saturation
// Optional feature: define SEG_AUTO_SCAN_EN for timed auto-advance between sources.
module seg_disp_arbiter #(
   parameter int NUM_SRC     = 3,
   parameter int TICK_CYC    = 5_000_000,
   parameter int BLANK_TICKS = 2,
   parameter int MAX_DISP    = 999_999,
   parameter int SCAN_TICKS  = 30
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst_n,
   input  logic                   key_next,
   input  logic [NUM_SRC-1:0]     src_vld,
   input  logic [32*NUM_SRC-1:0]  src_data,
   input  logic [6*NUM_SRC-1:0]   src_point,
   input  logic [NUM_SRC-1:0]     src_sign,
   output logic [31:0]            data,
   output logic [5:0]             point,
   output logic                   en,
   output logic                   sign,
   output logic [2:0]             sel,
   output logic                   ovf
);

   localparam int TW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
   localparam int BW = $clog2(BLANK_TICKS + 1);

   typedef enum logic [1:0] {S_INIT, S_SHOW, S_BLANK, S_NONE} state_t;

   state_t        state;
   logic [TW-1:0] cnt;
   logic [BW-1:0] blank_cnt;
   logic          tick;
   logic          any_vld;
   logic          cur_vld;
   logic [31:0]   cur_data;
   logic [5:0]    cur_point;
   logic          cur_sign;
   logic [2:0]    next_idx;
   logic [2:0]    low_idx;
   logic          scan_adv;
   logic          adv;
   logic          latch;
   int            j;

   assign tick = (cnt == TW'(TICK_CYC - 1));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         cnt <= '0;
      else if (tick)
         cnt <= '0;
      else
         cnt <= cnt + TW'(1);
   end

   assign any_vld   = |src_vld;
   assign cur_vld   = 1'(src_vld >> sel);
   assign cur_sign  = 1'(src_sign >> sel);
   assign cur_data  = 32'(src_data >> (32 * int'(sel)));
   assign cur_point = 6'(src_point >> (6 * int'(sel)));

   // Reverse-order scans: the last hit written wins, so the nearest candidate is kept.
   always_comb begin
      next_idx = sel;
      low_idx  = '0;
      j        = 0;
      for (int k = NUM_SRC; k >= 1; k--) begin
         j = int'(sel) + k;
         if (j >= NUM_SRC)
            j = j - NUM_SRC;
         if (1'(src_vld >> j))
            next_idx = 3'(j);
      end
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (1'(src_vld >> i))
            low_idx = 3'(i);
      end
   end

`ifdef SEG_AUTO_SCAN_EN
   localparam int DW = $clog2(SCAN_TICKS + 1);
   logic [DW-1:0] dwell;

   assign scan_adv = (state == S_SHOW) && tick && (dwell == DW'(SCAN_TICKS - 1));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         dwell <= '0;
      else if (state != S_SHOW || adv)
         dwell <= '0;
      else if (tick)
         dwell <= dwell + DW'(1);
   end
`else
   assign scan_adv = 1'b0;
`endif

   assign adv   = key_next || !cur_vld || scan_adv;
   assign latch = tick && any_vld && !adv &&
                  ((state == S_SHOW) || (state == S_BLANK && blank_cnt == BW'(1)));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         data  <= '0;
         point <= '0;
         sign  <= 1'b0;
         ovf   <= 1'b0;
      end else if (latch) begin
         data  <= (cur_data > 32'(MAX_DISP)) ? 32'(MAX_DISP) : cur_data;
         ovf   <= (cur_data > 32'(MAX_DISP));
         point <= cur_point;
         sign  <= cur_sign;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= S_INIT;
         sel       <= '0;
         en        <= 1'b0;
         blank_cnt <= '0;
      end else begin
         case (state)
            S_INIT: begin
               en <= 1'b0;
               if (tick) begin
                  if (any_vld) begin
                     sel       <= low_idx;
                     blank_cnt <= BW'(BLANK_TICKS);
                     state     <= S_BLANK;
                  end else begin
                     state <= S_NONE;
                  end
               end
            end
            S_SHOW: begin
               if (!any_vld) begin
                  en    <= 1'b0;
                  state <= S_NONE;
               end else if (adv) begin
                  sel       <= next_idx;
                  en        <= 1'b0;
                  blank_cnt <= BW'(BLANK_TICKS);
                  state     <= S_BLANK;
               end
            end
            S_BLANK: begin
               if (!any_vld) begin
                  state <= S_NONE;
               end else if (adv) begin
                  sel       <= next_idx;
                  blank_cnt <= BW'(BLANK_TICKS);
               end else if (tick) begin
                  blank_cnt <= blank_cnt - BW'(1);
                  if (blank_cnt == BW'(1)) begin
                     en    <= 1'b1;
                     state <= S_SHOW;
                  end
               end
            end
            default: begin
               en <= 1'b0;
               if (any_vld) begin
                  sel       <= low_idx;
                  blank_cnt <= BW'(BLANK_TICKS);
                  state     <= S_BLANK;
               end
            end
         endcase
      end
   end

endmodule
